// File: rtl/resample_pkg.sv
// ============================================================================
// Module   : resample_pkg
// Brief    : Shared constants, state encoding and ratio check for the
//            polyphase resampler command sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package resample_pkg;

    localparam int L              = 160;
    localparam int L_LOG          = 8;
    localparam int M              = 147;
    localparam int NR_STREAMS     = 16;
    localparam int NR_STREAMS_LOG = 4;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } seq_state_t;

    // At most one input shift per frame requires 0 < M <= L.
    function automatic bit ratio_ok(input int l, input int m);
        return (m > 0) && (m <= l);
    endfunction

    localparam bit c_ratio_ok = ratio_ok(L, M);

endpackage

`default_nettype wire

// File: rtl/resample_phase_acc.sv
// ============================================================================
// Module   : resample_phase_acc
// Brief    : Polyphase phase accumulator; advances one frame per frame_end
//            strobe, producing phase, shift flag and period_done pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module resample_phase_acc #(
    parameter int L     = resample_pkg::L,
    parameter int L_LOG = resample_pkg::L_LOG,
    parameter int M     = resample_pkg::M
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_end,
    output logic [L_LOG-1:0] phase,
    output logic             shift,
    output logic             period_done
);
    import resample_pkg::*;

    localparam logic [L_LOG:0]   c_m          = (L_LOG + 1)'(M);
    localparam logic [L_LOG:0]   c_l          = (L_LOG + 1)'(L);
    localparam logic [L_LOG-1:0] c_last_frame = L_LOG'(L - 1);

    logic [L_LOG-1:0] r_acc;
    logic [L_LOG-1:0] r_frame_idx;
    logic             r_shift;
    logic             r_period_done;

    logic [L_LOG:0]   w_sum;
    logic             w_wrap;
    logic [L_LOG-1:0] w_acc_nxt;
    logic             w_period_end;

    // One extra bit keeps acc+M exact before the wrap compare.
    assign w_sum        = {1'b0, r_acc} + c_m;
    assign w_wrap       = (w_sum >= c_l);
    assign w_acc_nxt    = w_wrap ? L_LOG'(w_sum - c_l) : w_sum[L_LOG-1:0];
    assign w_period_end = (r_frame_idx == c_last_frame);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc         <= '0;
            r_frame_idx   <= '0;
            r_shift       <= 1'b1;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= frame_end && w_period_end;
            if (frame_end) begin
                r_acc       <= w_acc_nxt;
                r_shift     <= w_wrap;
                r_frame_idx <= w_period_end ? '0 : r_frame_idx + 1'b1;
            end
        end
    end

    assign phase       = r_acc;
    assign shift       = r_shift;
    assign period_done = r_period_done;

endmodule

`default_nettype wire

// File: rtl/resample_sequencer.sv
// ============================================================================
// Module   : resample_sequencer
// Brief    : Round-robin per-stream command issuer for the L/M polyphase
//            resampler. Optional statistics counters under SEQ_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module resample_sequencer #(
    parameter int L              = resample_pkg::L,
    parameter int L_LOG          = resample_pkg::L_LOG,
    parameter int M              = resample_pkg::M,
    parameter int NR_STREAMS     = resample_pkg::NR_STREAMS,
    parameter int NR_STREAMS_LOG = resample_pkg::NR_STREAMS_LOG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    output logic                      cmd_req,
    input  logic                      cmd_ack,
    output logic [NR_STREAMS_LOG-1:0] cmd_stream,
    output logic [L_LOG-1:0]          cmd_phase,
    output logic                      cmd_shift,
    output logic                      cmd_first,
    output logic                      cmd_last,
    output logic                      period_done,
    output logic                      busy
`ifdef SEQ_STATS_EN
    ,
    output logic [31:0]               stat_stall_cnt,
    output logic [31:0]               stat_shift_cnt
`endif
);
    import resample_pkg::*;

    localparam logic [NR_STREAMS_LOG-1:0] c_last_stream = NR_STREAMS_LOG'(NR_STREAMS - 1);
    localparam logic                      c_single      = (NR_STREAMS == 1);

    if (!ratio_ok(L, M)) begin : g_bad_ratio
        $error("resample_sequencer: M must satisfy 0 < M <= L");
    end

    seq_state_t                r_state,  w_state_nxt;
    logic                      r_req,    w_req_nxt;
    logic [NR_STREAMS_LOG-1:0] r_stream, w_stream_nxt;
    logic                      r_first,  w_first_nxt;
    logic                      r_last,   w_last_nxt;

    logic w_accept;
    logic w_frame_end;

    assign w_accept    = r_req && cmd_ack;
    assign w_frame_end = w_accept && r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_req    <= 1'b0;
            r_stream <= '0;
            r_first  <= 1'b1;
            r_last   <= c_single;
        end else begin
            r_state  <= w_state_nxt;
            r_req    <= w_req_nxt;
            r_stream <= w_stream_nxt;
            r_first  <= w_first_nxt;
            r_last   <= w_last_nxt;
        end
    end

    // enable only matters in IDLE and at frame end; frames are never cut short.
    always_comb begin
        w_state_nxt  = r_state;
        w_req_nxt    = r_req;
        w_stream_nxt = r_stream;
        w_first_nxt  = r_first;
        w_last_nxt   = r_last;
        case (r_state)
            ST_IDLE: begin
                if (enable) begin
                    w_state_nxt = ST_ISSUE;
                    w_req_nxt   = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (w_accept) begin
                    if (!r_last) begin
                        w_stream_nxt = r_stream + 1'b1;
                        w_first_nxt  = 1'b0;
                        w_last_nxt   = ((r_stream + 1'b1) == c_last_stream);
                    end else begin
                        w_stream_nxt = '0;
                        w_first_nxt  = 1'b1;
                        w_last_nxt   = c_single;
                        if (!enable) begin
                            w_req_nxt   = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_req_nxt   = 1'b0;
            end
        endcase
    end

    resample_phase_acc #(
        .L     (L),
        .L_LOG (L_LOG),
        .M     (M)
    ) u_phase_acc (
        .clk         (clk),
        .rst         (rst),
        .frame_end   (w_frame_end),
        .phase       (cmd_phase),
        .shift       (cmd_shift),
        .period_done (period_done)
    );

    assign cmd_req    = r_req;
    assign cmd_stream = r_stream;
    assign cmd_first  = r_first;
    assign cmd_last   = r_last;
    assign busy       = (r_state != ST_IDLE);

`ifdef SEQ_STATS_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_shift_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_shift_cnt <= '0;
        end else begin
            if (r_req && !cmd_ack && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_frame_end && cmd_shift && (r_shift_cnt != '1))
                r_shift_cnt <= r_shift_cnt + 1'b1;
        end
    end

    assign stat_stall_cnt = r_stall_cnt;
    assign stat_shift_cnt = r_shift_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_resample_sequencer.sv
// ============================================================================
// Module   : tb_resample_sequencer
// Brief    : Self-checking bench for resample_sequencer against a frame-level
//            arithmetic reference model. Stats checks under SEQ_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_resample_sequencer;

    localparam int L  = 160;
    localparam int M  = 147;
    localparam int NR = 16;

    // {req, stream, phase, shift, first, last, period_done, busy}
    localparam logic [17:0] RST_VEC = {1'b0, 4'd0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       cmd_ack = 1'b0;
    logic       cmd_req;
    logic [3:0] cmd_stream;
    logic [7:0] cmd_phase;
    logic       cmd_shift, cmd_first, cmd_last, period_done, busy;
`ifdef SEQ_STATS_EN
    logic [31:0] stat_stall_cnt, stat_shift_cnt;
`endif

    always #5 clk = ~clk;

    resample_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .cmd_req     (cmd_req),
        .cmd_ack     (cmd_ack),
        .cmd_stream  (cmd_stream),
        .cmd_phase   (cmd_phase),
        .cmd_shift   (cmd_shift),
        .cmd_first   (cmd_first),
        .cmd_last    (cmd_last),
        .period_done (period_done),
        .busy        (busy)
`ifdef SEQ_STATS_EN
        ,
        .stat_stall_cnt (stat_stall_cnt),
        .stat_shift_cnt (stat_shift_cnt)
`endif
    );

    logic [17:0] dut_vec;
    assign dut_vec = {cmd_req, cmd_stream, cmd_phase, cmd_shift, cmd_first, cmd_last, period_done, busy};

    int tests = 0;
    int fails = 0;

    // Reference model: frames counted since reset, slot within frame.
    int m_frame = 0;
    int m_stream = 0;
    bit m_active = 0;
    bit m_pd = 0;
    int m_stall_cnt = 0;
    int m_shift_cnt = 0;

    function automatic bit frame_shift(input int k);
        int kk;
        kk = k % L;
        if (kk == 0) return 1'b1;
        return ((kk * M) / L) != (((kk - 1) * M) / L);
    endfunction

    function automatic logic [17:0] exp_vec();
        int kk;
        kk = m_frame % L;
        return {m_active, 4'(m_stream), 8'((kk * M) % L), frame_shift(m_frame),
                (m_stream == 0), (m_stream == NR - 1), m_pd, m_active};
    endfunction

    // Advance one clock and apply the protocol rules to the model.
    task automatic tick();
        bit stall;
        bit en;
        bit ack;
        stall = m_active && !cmd_ack;
        en    = enable;
        ack   = cmd_ack;
        @(posedge clk);
        if (rst) begin
            m_frame = 0; m_stream = 0; m_active = 0; m_pd = 0;
            m_stall_cnt = 0; m_shift_cnt = 0;
        end else begin
            m_pd = 0;
            if (stall) m_stall_cnt++;
            if (!m_active) begin
                if (en) m_active = 1;
            end else if (ack) begin
                if (m_stream == NR - 1) begin
                    if (frame_shift(m_frame)) m_shift_cnt++;
                    if (m_frame % L == L - 1) m_pd = 1;
                    m_frame++;
                    m_stream = 0;
                    if (!en) m_active = 0;
                end else begin
                    m_stream++;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; cmd_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (dut_vec !== RST_VEC) begin
                fails++;
                $display("FAIL reset_values: got %h expected %h", dut_vec, RST_VEC);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_stream_cycle();
        int ph[3] = '{0, 147, 134};
        bit sh[3] = '{1'b1, 1'b0, 1'b1};
        enable = 1'b1; cmd_ack = 1'b1;
        for (int i = 0; i < 52; i++) begin
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL stream_cycle: got %h expected %h", dut_vec, exp_vec());
            end
            if (m_active && m_stream == 0 && m_frame <= 2) begin
                tests++;
                if (cmd_phase !== 8'(ph[m_frame]) || cmd_shift !== sh[m_frame]) begin
                    fails++;
                    $display("FAIL frame_phase: frame %0d got phase %0d shift %0b expected %0d %0b",
                             m_frame, cmd_phase, cmd_shift, ph[m_frame], sh[m_frame]);
                end
            end
        end
    endtask

    task automatic test_full_period();
        int accepts = 0;
        int pd_cnt = 0;
        int shift_frames = 0;
        do_reset();
        enable = 1'b1; cmd_ack = 1'b1;
        for (int i = 0; i < 2700 && accepts < 2560; i++) begin
            if (cmd_req && cmd_ack) begin
                accepts++;
                if (cmd_first && cmd_shift) shift_frames++;
            end
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL full_period: got %h expected %h", dut_vec, exp_vec());
            end
            if (period_done) begin
                pd_cnt++;
                tests++;
                if (accepts != 2560) begin
                    fails++;
                    $display("FAIL period_done_pos: pulse after %0d accepts, expected 2560", accepts);
                end
            end
        end
        tests++;
        if (accepts != 2560 || pd_cnt != 1 || shift_frames != 147) begin
            fails++;
            $display("FAIL period_totals: accepts %0d pulses %0d shifts %0d expected 2560 1 147",
                     accepts, pd_cnt, shift_frames);
        end
        tests++;
        if (cmd_stream !== 4'd0 || cmd_phase !== 8'd0 || cmd_shift !== 1'b1) begin
            fails++;
            $display("FAIL frame160: stream %0d phase %0d shift %0b expected 0 0 1",
                     cmd_stream, cmd_phase, cmd_shift);
        end
`ifdef SEQ_STATS_EN
        tests++;
        if (stat_shift_cnt !== 32'd147) begin
            fails++;
            $display("FAIL stat_shift_period: got %0d expected 147", stat_shift_cnt);
        end
`endif
    endtask

    task automatic test_stall();
        logic [17:0] held;
`ifdef SEQ_STATS_EN
        logic [31:0] stall0;
`endif
        enable = 1'b1; cmd_ack = 1'b1;
        for (int i = 0; i < 40 && !(m_active && m_stream == 7); i++) tick();
        tests++;
        if (!(m_active && m_stream == 7) || cmd_stream !== 4'd7) begin
            fails++;
            $display("FAIL stall_reach: stream %0d expected 7", cmd_stream);
        end
        held = dut_vec;
`ifdef SEQ_STATS_EN
        stall0 = stat_stall_cnt;
`endif
        cmd_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++;
            if (dut_vec !== held || dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL stall_hold: got %h expected %h", dut_vec, held);
            end
        end
        cmd_ack = 1'b1;
        tick();
        tests++;
        if (cmd_stream !== 4'd8 || cmd_req !== 1'b1) begin
            fails++;
            $display("FAIL stall_resume: stream %0d req %0b expected 8 1", cmd_stream, cmd_req);
        end
`ifdef SEQ_STATS_EN
        tests++;
        if (stat_stall_cnt - stall0 !== 32'd5) begin
            fails++;
            $display("FAIL stat_stall: delta %0d expected 5", stat_stall_cnt - stall0);
        end
`endif
    endtask

    task automatic test_enable_drop();
        int accepts = 0;
        do_reset();
        enable = 1'b1; cmd_ack = 1'b1;
        for (int i = 0; i < 60 && !(m_frame == 1 && m_stream == 3); i++) tick();
        enable = 1'b0;
        for (int i = 0; i < 40 && m_active; i++) begin
            if (cmd_req && cmd_ack) accepts++;
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL enable_drop: got %h expected %h", dut_vec, exp_vec());
            end
        end
        tests++;
        if (accepts != 13 || cmd_req !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL drop_finish: accepts %0d req %0b busy %0b expected 13 0 0",
                     accepts, cmd_req, busy);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL idle_hold: got %h expected %h", dut_vec, exp_vec());
            end
        end
        enable = 1'b1;
        tick();
        tests++;
        if (cmd_req !== 1'b1 || cmd_stream !== 4'd0 || cmd_phase !== 8'd134 || cmd_shift !== 1'b1) begin
            fails++;
            $display("FAIL resume: req %0b stream %0d phase %0d shift %0b expected 1 0 134 1",
                     cmd_req, cmd_stream, cmd_phase, cmd_shift);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            enable  = ($urandom_range(0, 3) != 0);
            cmd_ack = 1'($urandom_range(0, 1));
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL random: cycle %0d got %h expected %h", i, dut_vec, exp_vec());
            end
        end
`ifdef SEQ_STATS_EN
        tests++;
        if (stat_stall_cnt !== 32'(m_stall_cnt) || stat_shift_cnt !== 32'(m_shift_cnt)) begin
            fails++;
            $display("FAIL random_stats: stall %0d shift %0d expected %0d %0d",
                     stat_stall_cnt, stat_shift_cnt, m_stall_cnt, m_shift_cnt);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        enable = 1'b1; cmd_ack = 1'b1;
        for (int i = 0; i < 60 && !(m_frame == 2 && m_stream == 9); i++) tick();
        tests++;
        if (cmd_stream !== 4'd9 || cmd_phase !== 8'd134) begin
            fails++;
            $display("FAIL midreset_reach: stream %0d phase %0d expected 9 134", cmd_stream, cmd_phase);
        end
        rst = 1'b1;
        tick();
        tests++;
        if (dut_vec !== RST_VEC) begin
            fails++;
            $display("FAIL midreset_values: got %h expected %h", dut_vec, RST_VEC);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            tests++;
            if (dut_vec !== exp_vec()) begin
                fails++;
                $display("FAIL midreset_restart: got %h expected %h", dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream_cycle();
        test_full_period();
        test_stall();
        test_enable_drop();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
